fmul_pipe: RTL and testbench

//  Pipelined IEEE-754 single-precision multiplier for the FPU.
//  It is the responder side of the FPU operation handshake (en/x1/x2 in, y/done/busy out),
//  so it sits beside the adder and is driven by the same issue logic and benches.
//  It accepts one operation per cycle and returns results in issue order after a fixed NSTAGE latency.

---
 rtl/fmul_pipe.sv | 150 +++++++++++++++
 tb/tb_fmul_pipe.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fmul_pipe.sv
// Pipelined binary32 multiplier: input capture, 3 compute stages, NSTAGE-3 output delays.
// Define FMUL_SPECIAL_EN to decode inf/NaN operands (exp field 255).
module fmul_pipe #(
    parameter int NSTAGE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        done,
    output logic        busy
);
    localparam int NX = NSTAGE - 3;

    // vld_q[0] is the input capture rank, vld_q[NSTAGE] drives done
    logic [NSTAGE:0]  vld_q, vld_d;
    logic             busy_q, busy_d;
    logic [31:0]      a_q, b_q;

    logic             s1_sign_q, s1_zero_q, s1_nan_q, s1_inf_q;
    logic             s1_sign_d, s1_zero_d, s1_nan_d, s1_inf_d;
    logic signed [9:0] s1_esum_q, s1_esum_d;
    logic [23:0]      s1_ma_q, s1_mb_q, s1_ma_d, s1_mb_d;

    logic             s2_sign_q, s2_zero_q, s2_nan_q, s2_inf_q;
    logic signed [9:0] s2_esum_q;
    logic [47:0]      s2_prod_q, s2_prod_d;

    logic [NX:0][31:0] y_pipe_q, y_pipe_d;

    // Stage 1: unpack, flush denormals, bias-corrected exponent sum
    always_comb begin
        logic [7:0] ea, eb;
        logic       za, zb;
        ea = a_q[30:23];
        eb = b_q[30:23];
        za = (ea == 8'd0);
        zb = (eb == 8'd0);
        s1_sign_d = a_q[31] ^ b_q[31];
        s1_zero_d = za | zb;
        s1_esum_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        s1_ma_d   = {1'b1, a_q[22:0]};
        s1_mb_d   = {1'b1, b_q[22:0]};
`ifdef FMUL_SPECIAL_EN
        begin
            logic a_inf, b_inf, a_nan, b_nan;
            a_inf = (ea == 8'hff) && (a_q[22:0] == 23'd0);
            b_inf = (eb == 8'hff) && (b_q[22:0] == 23'd0);
            a_nan = (ea == 8'hff) && (a_q[22:0] != 23'd0);
            b_nan = (eb == 8'hff) && (b_q[22:0] != 23'd0);
            s1_nan_d = a_nan | b_nan | (a_inf & zb) | (b_inf & za);
            s1_inf_d = (a_inf | b_inf) & ~s1_nan_d;
        end
`else
        s1_nan_d = 1'b0;
        s1_inf_d = 1'b0;
`endif
    end

    // Stage 2: full-width mantissa product
    always_comb begin
        s2_prod_d = 48'(s1_ma_q) * 48'(s1_mb_q);
    end

    // Stage 3: normalize, round to nearest-even, pack
    always_comb begin
        logic [22:0]       mant;
        logic              grd, sticky, rnd;
        logic [23:0]       mr;
        logic signed [9:0] e, er;
        if (s2_prod_q[47]) begin
            mant   = s2_prod_q[46:24];
            grd    = s2_prod_q[23];
            sticky = |s2_prod_q[22:0];
            e      = s2_esum_q + 10'sd1;
        end else begin
            mant   = s2_prod_q[45:23];
            grd    = s2_prod_q[22];
            sticky = |s2_prod_q[21:0];
            e      = s2_esum_q;
        end
        rnd = grd & (sticky | mant[0]);
        mr  = {1'b0, mant} + {23'd0, rnd};
        // all-ones mantissa rounding up wraps to 1.0 at the next exponent
        er  = e + $signed({9'd0, mr[23]});
        if (s2_nan_q)
            y_pipe_d[0] = 32'h7fc0_0000;
        else if (s2_inf_q || (!s2_zero_q && er >= 10'sd255))
            y_pipe_d[0] = {s2_sign_q, 8'hff, 23'd0};
        else if (s2_zero_q || er <= 10'sd0)
            y_pipe_d[0] = {s2_sign_q, 31'd0};
        else
            y_pipe_d[0] = {s2_sign_q, er[7:0], mr[22:0]};
        for (int i = 1; i <= NX; i++)
            y_pipe_d[i] = y_pipe_q[i-1];
    end

    always_comb begin
        vld_d  = {vld_q[NSTAGE-1:0], en};
        busy_d = |vld_q[NSTAGE-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            busy_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            s1_sign_q <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_nan_q  <= 1'b0;
            s1_inf_q  <= 1'b0;
            s1_esum_q <= '0;
            s1_ma_q   <= '0;
            s1_mb_q   <= '0;
            s2_sign_q <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_nan_q  <= 1'b0;
            s2_inf_q  <= 1'b0;
            s2_esum_q <= '0;
            s2_prod_q <= '0;
            y_pipe_q  <= '0;
        end else begin
            vld_q     <= vld_d;
            busy_q    <= busy_d;
            a_q       <= x1;
            b_q       <= x2;
            s1_sign_q <= s1_sign_d;
            s1_zero_q <= s1_zero_d;
            s1_nan_q  <= s1_nan_d;
            s1_inf_q  <= s1_inf_d;
            s1_esum_q <= s1_esum_d;
            s1_ma_q   <= s1_ma_d;
            s1_mb_q   <= s1_mb_d;
            s2_sign_q <= s1_sign_q;
            s2_zero_q <= s1_zero_q;
            s2_nan_q  <= s1_nan_q;
            s2_inf_q  <= s1_inf_q;
            s2_esum_q <= s1_esum_q;
            s2_prod_q <= s2_prod_d;
            y_pipe_q  <= y_pipe_d;
        end
    end

    assign y    = y_pipe_q[NX];
    assign done = vld_q[NSTAGE];
    assign busy = busy_q;
endmodule

// File: tb/tb_fmul_pipe.sv
// Scoreboard bench for fmul_pipe: directed cases, reset flush, random sweep vs real-number model.
module tb_fmul_pipe;
    localparam int NSTAGE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [31:0] x1  = '0;
    logic [31:0] x2  = '0;
    logic [31:0] y;
    logic        done;
    logic        busy;

    fmul_pipe #(.NSTAGE(NSTAGE)) dut (
        .clk(clk), .rst(rst), .en(en), .x1(x1), .x2(x2),
        .y(y), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          iss;
        logic [31:0] y;
        bit          skip;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // bit 32 set means the reference lands in the denormal range and is not compared
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        real         fa, fb, fp;
        logic [31:0] r;
        s = a[31] ^ b[31];
`ifdef FMUL_SPECIAL_EN
        if ((a[30:23] == 8'hff && a[22:0] != 0) || (b[30:23] == 8'hff && b[22:0] != 0))
            return {1'b0, 32'h7fc0_0000};
        if (a[30:23] == 8'hff)
            return (b[30:23] == 8'h00) ? {1'b0, 32'h7fc0_0000} : {1'b0, s, 8'hff, 23'd0};
        if (b[30:23] == 8'hff)
            return (a[30:23] == 8'h00) ? {1'b0, 32'h7fc0_0000} : {1'b0, s, 8'hff, 23'd0};
`endif
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00)
            return {1'b0, s, 31'd0};
        fa = $bitstoshortreal(a);
        fb = $bitstoshortreal(b);
        fp = fa * fb;
        r  = $shortrealtobits(fp);
        return {(r[30:23] == 8'h00), r};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input bit skip);
        exp_t e;
        x1 = a;
        x2 = b;
        en = 1'b1;
        e.iss  = cyc + 1;
        e.y    = want;
        e.skip = skip;
        q.push_back(e);
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic issue_ref(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        r = ref_mul(a, b);
        issue(a, b, r[31:0], r[32]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output side of the scoreboard: busy window, latency and value per done pulse
    always @(negedge clk) begin
        if (!rst) begin
            logic exp_busy;
            exp_t e;
            exp_busy = (q.size() > 0) && (q[0].iss < cyc);
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("latency", 32'(cyc), 32'(e.iss + NSTAGE));
                    if (!e.skip) chk("y", y, e.y);
                end
            end
        end
    end

    initial begin
        #1;
        chk("reset_y", y, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        idle(2);
        rst = 1'b0;
        idle(2);

        issue(32'h3f80_0000, 32'h3f80_0000, 32'h3f80_0000, 1'b0);
        idle(NSTAGE + 2);
        issue(32'h3fc0_0000, 32'hc000_0000, 32'hc040_0000, 1'b0);
        issue(32'h3f80_0001, 32'h3f80_0001, 32'h3f80_0002, 1'b0);
        idle(NSTAGE + 2);

        issue(32'h3f80_0000, 32'h4000_0000, 32'h4000_0000, 1'b0);
        issue(32'h4000_0000, 32'h4040_0000, 32'h40c0_0000, 1'b0);
        issue(32'h4040_0000, 32'h4080_0000, 32'h4140_0000, 1'b0);
        idle(NSTAGE + 2);

        issue(32'h7f00_0000, 32'h7f00_0000, 32'h7f80_0000, 1'b0);
        issue(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0);
        issue(32'h8000_0000, 32'h3f80_0000, 32'h8000_0000, 1'b0);
        issue(32'h7f80_0000, 32'h3f80_0000, 32'h7f80_0000, 1'b0);
        issue(32'h0000_0001, 32'hbf80_0000, 32'h8000_0000, 1'b0);
        issue(32'h3f7f_ffff, 32'h3f80_0001, 32'h3f80_0000, 1'b0);
`ifdef FMUL_SPECIAL_EN
        issue(32'h7f80_0000, 32'h0000_0000, 32'h7fc0_0000, 1'b0);
        issue(32'hff80_0000, 32'h4000_0000, 32'hff80_0000, 1'b0);
        issue(32'h7fc0_1234, 32'h3f80_0000, 32'h7fc0_0000, 1'b0);
`endif
        idle(NSTAGE + 2);

        // Reset with an op in flight: outputs clear at once and the op never completes
        issue(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_y", y, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        q.delete();
        #1;
        rst = 1'b0;
        idle(NSTAGE + 4);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
`ifdef FMUL_SPECIAL_EN
            a = {1'($urandom), 8'($urandom_range(0, 255)), 23'($urandom)};
            b = {1'($urandom), 8'($urandom_range(0, 255)), 23'($urandom)};
`else
            a = {1'($urandom), 8'($urandom_range(0, 254)), 23'($urandom)};
            b = {1'($urandom), 8'($urandom_range(0, 254)), 23'($urandom)};
`endif
            issue_ref(a, b);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(NSTAGE + 3);
        chk("drain", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
